// File: rtl/scmp_dly_timer.sv
// SC/MP DLY engine: counts 13 + 2*AC + 514*disp microcycles of CLKS_PER_UCYCLE clocks each.
// Latency: done pulses T*K clocks after the accepting edge; busy is high for exactly T*K cycles.
// Backpressure: start is only taken in IDLE with en=1; en=0 freezes all state, abort cancels.
module scmp_dly_timer #(
  parameter int CLKS_PER_UCYCLE = 50,
  parameter int UCYC_W          = 18,
  parameter int PRE_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        ac_in,
  input  logic [7:0]        disp_in,
  output logic              busy,
  output logic              done,
  output logic [7:0]        ac_out,
  output logic [UCYC_W-1:0] ucyc_left
);

`ifdef SIMULATION
  localparam int K_EFF = 1;
`else
  localparam int K_EFF = CLKS_PER_UCYCLE;
`endif

  localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(K_EFF - 1);
  localparam logic [UCYC_W-1:0] UCYC_ONE   = UCYC_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        ac_q, ac_d;
  logic [UCYC_W-1:0] ucyc_q, ucyc_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [UCYC_W-1:0] t_total;

  // Delay length in microcycles; 514*disp folds the inner 2*disp and outer 512*disp loops.
  always_comb begin
    t_total = UCYC_W'(13)
            + (UCYC_W'(ac_in) << 1)
            + (UCYC_W'(disp_in) * UCYC_W'(514));
  end

  // Next-state logic; nothing moves unless en is high.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ac_d    = ac_q;
    ucyc_d  = ucyc_q;
    pre_d   = pre_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          done_d = 1'b0;
          if (start && !abort) begin
            ac_d    = ac_in;
            ucyc_d  = t_total;
            pre_d   = PRE_RELOAD;
            busy_d  = 1'b1;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            // Cancel keeps the latched AC so the core sees its original value.
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ucyc_d  = '0;
            state_d = ST_IDLE;
          end else if (pre_q != '0) begin
            pre_d = pre_q - PRE_W'(1);
          end else begin
            pre_d = PRE_RELOAD;
            if (ucyc_q == UCYC_ONE) begin
              ucyc_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              ac_d    = 8'hFF;
              state_d = ST_IDLE;
            end else begin
              ucyc_d = ucyc_q - UCYC_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; async reset discards any delay in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ac_q    <= 8'h00;
      ucyc_q  <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ac_q    <= ac_d;
      ucyc_q  <= ucyc_d;
      pre_q   <= pre_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ac_out    = ac_q;
  assign ucyc_left = ucyc_q;

endmodule

// File: tb/tb_scmp_dly_timer.sv
// Bench for scmp_dly_timer: directed literal cases plus randomized traffic vs. an elapsed-clock model.
// Latency: model predicts outputs after every edge; compared on each falling edge.
// Backpressure: en, start and abort are randomized, including an async reset mid-run.
module tb_scmp_dly_timer;

`ifdef SIMULATION
  localparam int K = 1;
`else
  localparam int K = 3;
`endif
  localparam int UW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, start, abort;
  logic [7:0]    ac_in, disp_in;
  logic          busy, done;
  logic [7:0]    ac_out;
  logic [UW-1:0] ucyc_left;

  int checks = 0;
  int errors = 0;

  scmp_dly_timer #(.CLKS_PER_UCYCLE(3), .UCYC_W(UW), .PRE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .abort     (abort),
    .ac_in     (ac_in),
    .disp_in   (disp_in),
    .busy      (busy),
    .done      (done),
    .ac_out    (ac_out),
    .ucyc_left (ucyc_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a delay is just "T microcycles worth of K clocks", tracked as elapsed clocks.
  logic m_busy, m_done;
  int   m_ac, m_t, m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_ac = 0; m_t = 0; m_n = 0;
    end else if (en) begin
      if (!m_busy) begin
        m_done = 1'b0;
        if (start && !abort) begin
          m_busy = 1'b1;
          m_t    = 13 + 2 * int'(ac_in) + 514 * int'(disp_in);
          m_n    = 0;
          m_ac   = int'(ac_in);
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else begin
        m_n++;
        if (m_n == m_t * K) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_ac   = 255;
        end
      end
    end
  end

  function automatic int m_ucyc();
    return m_busy ? (m_t - m_n / K) : 0;
  endfunction

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("ac_out", int'(ac_out), m_ac);
    chk("ucyc_left", int'(ucyc_left), m_ucyc());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0; ac_in = 8'h00; disp_in = 8'h00;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ac", int'(ac_out), 0);
    chk("rst_ucyc", int'(ucyc_left), 0);
    #5 rst_n = 1'b1;
    tick();

    // Shortest delay: 13 microcycles, done then stretched while en is low.
    start = 1'b1; ac_in = 8'h00; disp_in = 8'h00;
    tick();
    start = 1'b0;
    chk("t0_ucyc_first", int'(ucyc_left), 13);
    wait_done(13 * K + 10, n);
    chk("t0_latency", n, 13 * K);
    chk("t0_ac_ff", int'(ac_out), 255);
    chk("t0_ucyc_zero", int'(ucyc_left), 0);
    en = 1'b0;
    repeat (5) tick();
    chk("t0_done_stretch", int'(done), 1);
    en = 1'b1;
    tick();
    chk("t0_done_clear", int'(done), 0);

    // T = 537, one microcycle step after K clocks, then abort.
    start = 1'b1; ac_in = 8'h05; disp_in = 8'h01;
    tick();
    start = 1'b0;
    chk("t1_ucyc", int'(ucyc_left), 537);
    repeat (K) tick();
    chk("t1_ucyc_step", int'(ucyc_left), 536);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t1_abort_busy", int'(busy), 0);
    chk("t1_abort_ac", int'(ac_out), 5);

    // Largest delay loads without overflow.
    start = 1'b1; ac_in = 8'hFF; disp_in = 8'hFF;
    tick();
    start = 1'b0;
    chk("tmax_ucyc", int'(ucyc_left), 131593);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // T = 1073 aborted after 100 clocks: no done, AC preserved.
    start = 1'b1; ac_in = 8'h10; disp_in = 8'h02;
    tick();
    start = 1'b0;
    chk("t2_ucyc", int'(ucyc_left), 1073);
    repeat (99) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_abort_busy", int'(busy), 0);
    chk("t2_abort_done", int'(done), 0);
    chk("t2_abort_ac", int'(ac_out), 16);
    tick();
    chk("t2_no_done", int'(done), 0);

    // Freeze for 50 cycles, stray start while busy, start held through done.
    start = 1'b1; ac_in = 8'h00; disp_in = 8'h00;
    tick();
    start = 1'b0;
    repeat (5) tick();
    en = 1'b0;
    repeat (50) tick();
    en = 1'b1;
    start = 1'b1;
    wait_done(13 * K + 20, n);
    chk("t3_latency", n + 55, 13 * K + 50);
    tick();
    chk("t3_b2b_busy", int'(busy), 1);
    chk("t3_b2b_done", int'(done), 0);
    chk("t3_b2b_ucyc", int'(ucyc_left), 13);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // Randomized traffic with one async reset mid-count.
    for (int c = 0; c < 20000; c++) begin
      tick();
      en      = ($urandom_range(0, 9) != 0);
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 299) == 0);
      ac_in   = 8'($urandom);
      disp_in = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
      if (c == 7000) begin
        en = 1'b1; start = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        repeat (20) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ac", int'(ac_out), 0);
        chk("arst_ucyc", int'(ucyc_left), 0);
        #4 rst_n = 1'b1;
      end
    end

    start = 1'b0; abort = 1'b0; en = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
